// File: rtl/dma_byp_pkg.sv
// dma_byp_pkg
// Shared types for the XDMA descriptor-bypass scheduler.
//   DESC_LEN_W : width of the XDMA bypass descriptor length field
//   TAG_CH_W   : channel field width in a completion tag (covers up to 8 channels)
//   state_e    : scheduler FSM states
//   tag_t      : completion tag {channel, last}, one per issued descriptor
package dma_byp_pkg;

    localparam int DESC_LEN_W = 28;
    localparam int TAG_CH_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic [TAG_CH_W-1:0] channel;
        logic                last;
    } tag_t;

endpackage

// File: rtl/dma_byp_tag_fifo.sv
// dma_byp_tag_fifo
// Synchronous FIFO of completion tags, one entry per outstanding descriptor.
// Pushes while full and pops while empty are ignored.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_tag
//   push_tag    : tag to store
//   pop         : discard the head entry
//   head        : oldest entry (valid when empty is low)
//   full, empty : occupancy flags
//   count       : number of stored entries
module dma_byp_tag_fifo
    import dma_byp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  tag_t                     push_tag,
    input  logic                     pop,
    output tag_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_byp_scheduler.sv
// dma_byp_scheduler
// Round-robin arbiter over NUM_CH command sources that splits each command
// into XDMA bypass descriptors of at most MAX_CHUNK bytes, tracks completions
// in issue order through a tag FIFO and reports per-channel command done.
// Build option: define DMA_BYP_ALIGN_SPLIT_EN to also split descriptors at
// MAX_CHUNK-aligned address boundaries; undefined splits on length only.
// Ports:
//   pcie_clk, pcie_aresetn     : clock, asynchronous active-low reset
//   s_cmd_valid / s_cmd_ready  : per-channel command handshake (ready one-hot)
//   s_cmd_addr, s_cmd_len      : per-channel command, channel i in slice i
//   dsc_byp_*                  : XDMA descriptor bypass (load/ready handshake)
//   desc_done                  : one descriptor completed, in issue order
//   cmd_done                   : pulse, last descriptor of a command completed
//   cmd_err                    : pulse, zero-length command discarded
//   outstanding                : issued but uncompleted descriptors
//
// state | meaning
// IDLE  | arbitrating; grant one command and latch it
// ISSUE | presenting descriptors until the last chunk transfers
module dma_byp_scheduler
    import dma_byp_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 32,
    parameter int MAX_CHUNK = 4096,
    parameter int TAG_DEPTH = 16
) (
    input  logic                        pcie_clk,
    input  logic                        pcie_aresetn,
    input  logic [NUM_CH-1:0]           s_cmd_valid,
    output logic [NUM_CH-1:0]           s_cmd_ready,
    input  logic [NUM_CH*ADDR_W-1:0]    s_cmd_addr,
    input  logic [NUM_CH*LEN_W-1:0]     s_cmd_len,
    input  logic                        dsc_byp_ready,
    output logic [ADDR_W-1:0]           dsc_byp_addr,
    output logic [DESC_LEN_W-1:0]       dsc_byp_len,
    output logic                        dsc_byp_load,
    input  logic                        desc_done,
    output logic [NUM_CH-1:0]           cmd_done,
    output logic [NUM_CH-1:0]           cmd_err,
    output logic [$clog2(TAG_DEPTH):0]  outstanding
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AL_W  = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int CW    = (AL_W > DESC_LEN_W) ? AL_W : DESC_LEN_W;

    // Reset asserts asynchronously, releases after two pcie_clk edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [LEN_W-1:0]  len_arr  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
        assign addr_arr[g] = s_cmd_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = s_cmd_len[g*LEN_W +: LEN_W];
    end

    state_e            state;
    logic              run;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  cur_ch;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;

    // Round-robin search starting at rr_ptr (channel after the last grant).
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_any && s_cmd_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // run holds off grants until the first edge after reset release, so no
    // command is accepted while the synchroniser is still settling.
    logic accept;
    assign accept      = run && (state == IDLE) && grant_any;
    assign s_cmd_ready = accept ? (NUM_CH'(1) << grant_idx) : '0;

    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    assign sel_addr = addr_arr[grant_idx];
    assign sel_len  = len_arr[grant_idx];

    logic [CW-1:0] rem_w;
    logic [CW-1:0] room;
    logic [CW-1:0] chunk;
    logic          chunk_last;

    always_comb begin
        rem_w = CW'(remaining);
`ifdef DMA_BYP_ALIGN_SPLIT_EN
        room  = CW'(MAX_CHUNK) - CW'(cur_addr & ADDR_W'(MAX_CHUNK - 1));
`else
        room  = CW'(MAX_CHUNK);
`endif
        chunk      = (rem_w < room) ? rem_w : room;
        chunk_last = (rem_w <= room);
    end

    logic fifo_full;
    logic fifo_empty;
    logic fire;
    tag_t push_tag;
    tag_t head_tag;

    assign dsc_byp_load = (state == ISSUE) && !fifo_full;
    assign dsc_byp_addr = cur_addr;
    assign dsc_byp_len  = chunk[DESC_LEN_W-1:0];
    assign fire         = dsc_byp_load && dsc_byp_ready;

    assign push_tag.channel = TAG_CH_W'(cur_ch);
    assign push_tag.last    = chunk_last;

    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            cmd_err   <= '0;
        end else begin
            run     <= 1'b1;
            cmd_err <= '0;
            if (state == IDLE) begin
                if (accept) begin
                    rr_ptr    <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                    cur_ch    <= grant_idx;
                    cur_addr  <= sel_addr;
                    remaining <= sel_len;
                    if (sel_len == '0) begin
                        cmd_err <= NUM_CH'(1) << grant_idx;
                    end else begin
                        state <= ISSUE;
                    end
                end
            end else begin
                if (fire) begin
                    cur_addr  <= cur_addr + ADDR_W'(chunk);
                    remaining <= remaining - LEN_W'(chunk);
                    if (chunk_last) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

    dma_byp_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (pcie_clk),
        .rst_n    (rst_n),
        .push     (fire),
        .push_tag (push_tag),
        .pop      (desc_done),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

    // Completion is reported in the same cycle as the pop of a last tag.
    assign cmd_done = (desc_done && !fifo_empty && head_tag.last)
                    ? (NUM_CH'(1) << head_tag.channel) : '0;

endmodule

// File: tb/tb_dma_byp_scheduler.sv
// tb_dma_byp_scheduler
// Directed bench for dma_byp_scheduler (NUM_CH=2, MAX_CHUNK=4096, TAG_DEPTH=4).
// Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_dma_byp_scheduler;

    logic         pcie_clk;
    logic         pcie_aresetn;
    logic [1:0]   s_cmd_valid;
    logic [1:0]   s_cmd_ready;
    logic [127:0] s_cmd_addr;
    logic [63:0]  s_cmd_len;
    logic         dsc_byp_ready;
    logic [63:0]  dsc_byp_addr;
    logic [27:0]  dsc_byp_len;
    logic         dsc_byp_load;
    logic         desc_done;
    logic [1:0]   cmd_done;
    logic [1:0]   cmd_err;
    logic [2:0]   outstanding;

    int vectors     = 0;
    int miscompares = 0;

    dma_byp_scheduler #(
        .NUM_CH    (2),
        .ADDR_W    (64),
        .LEN_W     (32),
        .MAX_CHUNK (4096),
        .TAG_DEPTH (4)
    ) dut (
        .pcie_clk      (pcie_clk),
        .pcie_aresetn  (pcie_aresetn),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_addr    (s_cmd_addr),
        .s_cmd_len     (s_cmd_len),
        .dsc_byp_ready (dsc_byp_ready),
        .dsc_byp_addr  (dsc_byp_addr),
        .dsc_byp_len   (dsc_byp_len),
        .dsc_byp_load  (dsc_byp_load),
        .desc_done     (desc_done),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .outstanding   (outstanding)
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int ch, input logic [63:0] addr, input logic [31:0] len);
        s_cmd_addr[ch*64 +: 64] = addr;
        s_cmd_len[ch*32 +: 32]  = len;
    endtask

    // Pulse desc_done n cycles; only the final pulse completes a command.
    task automatic drain(input int n, input logic [1:0] last_done);
        for (int i = 0; i < n; i++) begin
            desc_done = 1'b1;
            #1;
            chk("drain_cmd_done", cmd_done, (i == n - 1) ? last_done : 2'b00);
            tick();
        end
        desc_done = 1'b0;
        #1;
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        pcie_aresetn  = 1'b0;
        s_cmd_valid   = 2'b00;
        s_cmd_addr    = '0;
        s_cmd_len     = '0;
        dsc_byp_ready = 1'b0;
        desc_done     = 1'b0;

        // Reset state, with valid and desc_done asserted against it.
        tick();
        set_cmd(0, 64'h1000, 32'd64);
        s_cmd_valid = 2'b11;
        desc_done   = 1'b1;
        #1;
        chk("rst_ready", s_cmd_ready, 0);
        chk("rst_load", dsc_byp_load, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_addr", dsc_byp_addr, 0);
        chk("rst_len", dsc_byp_len, 0);
        chk("rst_cmd_done", cmd_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        s_cmd_valid  = 2'b00;
        desc_done    = 1'b0;
        pcie_aresetn = 1'b1;
        repeat (4) tick();

        // 10000 bytes at 0x1000 -> 4096, 4096, 1808 back to back.
        set_cmd(0, 64'h1000, 32'd10000);
        s_cmd_valid   = 2'b01;
        dsc_byp_ready = 1'b1;
        #1;
        chk("split_grant", s_cmd_ready, 2'b01);
        tick();
        s_cmd_valid = 2'b00;
        #1;
        chk("split_load0", dsc_byp_load, 1);
        chk("split_addr0", dsc_byp_addr, 64'h1000);
        chk("split_len0", dsc_byp_len, 4096);
        chk("split_ready_issue", s_cmd_ready, 0);
        tick();
        #1;
        chk("split_addr1", dsc_byp_addr, 64'h2000);
        chk("split_len1", dsc_byp_len, 4096);
        chk("split_out1", outstanding, 1);
        tick();
        #1;
        chk("split_addr2", dsc_byp_addr, 64'h3000);
        chk("split_len2", dsc_byp_len, 1808);
        chk("split_load2", dsc_byp_load, 1);
        tick();
        #1;
        chk("split_load_end", dsc_byp_load, 0);
        chk("split_out3", outstanding, 3);
        drain(3, 2'b01);

        // desc_done with nothing outstanding is ignored.
        desc_done = 1'b1;
        #1;
        chk("empty_pop_cmd_done", cmd_done, 0);
        tick();
        desc_done = 1'b0;
        #1;
        chk("empty_pop_outstanding", outstanding, 0);

        // 512 bytes at 0x0F00: boundary split only with the alignment option.
        set_cmd(0, 64'h0F00, 32'd512);
        s_cmd_valid = 2'b01;
        #1;
        chk("align_grant", s_cmd_ready, 2'b01);
        tick();
        s_cmd_valid = 2'b00;
        #1;
`ifdef DMA_BYP_ALIGN_SPLIT_EN
        chk("align_addr0", dsc_byp_addr, 64'h0F00);
        chk("align_len0", dsc_byp_len, 256);
        tick();
        #1;
        chk("align_addr1", dsc_byp_addr, 64'h1000);
        chk("align_len1", dsc_byp_len, 256);
        tick();
        #1;
        chk("align_load_end", dsc_byp_load, 0);
        drain(2, 2'b01);
`else
        chk("align_addr0", dsc_byp_addr, 64'h0F00);
        chk("align_len0", dsc_byp_len, 512);
        tick();
        #1;
        chk("align_load_end", dsc_byp_load, 0);
        drain(1, 2'b01);
`endif

        // Zero-length command on channel 1: error pulse, nothing issued.
        set_cmd(1, 64'h5000, 32'd0);
        s_cmd_valid = 2'b10;
        #1;
        chk("zero_grant", s_cmd_ready, 2'b10);
        chk("zero_err_early", cmd_err, 0);
        tick();
        s_cmd_valid = 2'b00;
        #1;
        chk("zero_err", cmd_err, 2'b10);
        chk("zero_load", dsc_byp_load, 0);
        tick();
        #1;
        chk("zero_err_clear", cmd_err, 0);
        chk("zero_load_after", dsc_byp_load, 0);
        chk("zero_outstanding", outstanding, 0);

        // Both channels continuously valid: grants alternate 0,1,0,1.
        set_cmd(0, 64'h100, 32'd64);
        set_cmd(1, 64'h200, 32'd64);
        s_cmd_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", s_cmd_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            if (k == 3) s_cmd_valid = 2'b00;
            #1;
            chk("rr_ready_issue", s_cmd_ready, 0);
            chk("rr_load", dsc_byp_load, 1);
            chk("rr_addr", dsc_byp_addr, (k % 2 == 1) ? 64'h200 : 64'h100);
            chk("rr_len", dsc_byp_len, 64);
            tick();
        end
        #1;
        chk("rr_outstanding", outstanding, 4);
        for (int k = 0; k < 4; k++) begin
            desc_done = 1'b1;
            #1;
            chk("rr_cmd_done", cmd_done, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
        end
        desc_done = 1'b0;
        #1;
        chk("rr_drained", outstanding, 0);

        // Tag FIFO backpressure: 8 x 4096 with depth 4.
        set_cmd(0, 64'h10000, 32'd32768);
        s_cmd_valid = 2'b01;
        #1;
        chk("full_grant", s_cmd_ready, 2'b01);
        tick();
        s_cmd_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_load", dsc_byp_load, 1);
            chk("full_addr", dsc_byp_addr, 64'h10000 + 64'(i) * 64'h1000);
            tick();
        end
        #1;
        chk("full_load_low", dsc_byp_load, 0);
        chk("full_outstanding", outstanding, 4);
        tick();
        #1;
        chk("full_load_held", dsc_byp_load, 0);
        chk("full_addr_held", dsc_byp_addr, 64'h14000);
        desc_done = 1'b1;
        #1;
        chk("full_pop_cmd_done", cmd_done, 0);
        tick();
        desc_done = 1'b0;
        #1;
        chk("full_one_more_load", dsc_byp_load, 1);
        chk("full_one_more_addr", dsc_byp_addr, 64'h14000);
        chk("full_after_pop", outstanding, 3);
        tick();
        #1;
        chk("full_again_load", dsc_byp_load, 0);
        chk("full_again_out", outstanding, 4);
        chk("full_again_addr", dsc_byp_addr, 64'h15000);

        // Reset in ISSUE with completions pending.
        pcie_aresetn = 1'b0;
        desc_done    = 1'b1;
        #1;
        chk("rst_issue_load", dsc_byp_load, 0);
        chk("rst_issue_out", outstanding, 0);
        chk("rst_issue_addr", dsc_byp_addr, 0);
        chk("rst_issue_cmd_done", cmd_done, 0);
        desc_done    = 1'b0;
        pcie_aresetn = 1'b1;
        repeat (4) tick();

        // Hold under ready low, then reset after 2 of 3 chunks.
        set_cmd(0, 64'h1000, 32'd10000);
        s_cmd_valid   = 2'b01;
        dsc_byp_ready = 1'b0;
        #1;
        chk("mid_grant", s_cmd_ready, 2'b01);
        tick();
        s_cmd_valid = 2'b00;
        #1;
        chk("mid_load", dsc_byp_load, 1);
        tick();
        #1;
        chk("hold_addr", dsc_byp_addr, 64'h1000);
        chk("hold_len", dsc_byp_len, 4096);
        chk("hold_out", outstanding, 0);
        dsc_byp_ready = 1'b1;
        tick();
        #1;
        chk("mid_addr1", dsc_byp_addr, 64'h2000);
        tick();
        #1;
        chk("mid_addr2", dsc_byp_addr, 64'h3000);
        chk("mid_out2", outstanding, 2);
        pcie_aresetn = 1'b0;
        #1;
        chk("mid_rst_load", dsc_byp_load, 0);
        chk("mid_rst_addr", dsc_byp_addr, 0);
        chk("mid_rst_len", dsc_byp_len, 0);
        chk("mid_rst_out", outstanding, 0);

        // Release: no grant while the reset release is still synchronising.
        set_cmd(1, 64'h40000, 32'd100);
        s_cmd_valid  = 2'b10;
        pcie_aresetn = 1'b1;
        #1;
        chk("rel_ready0", s_cmd_ready, 0);
        tick();
        #1;
        chk("rel_ready1", s_cmd_ready, 0);
        tick();
        #1;
        chk("rel_ready2", s_cmd_ready, 0);
        tick();
        #1;
        chk("rel_grant", s_cmd_ready, 2'b10);
        tick();
        s_cmd_valid = 2'b00;
        #1;
        chk("rel_addr", dsc_byp_addr, 64'h40000);
        chk("rel_len", dsc_byp_len, 100);
        chk("rel_load", dsc_byp_load, 1);
        tick();
        #1;
        chk("rel_load_end", dsc_byp_load, 0);
        chk("rel_out", outstanding, 1);
        drain(1, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
